// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM controller: FSM state encoding,
// byte-lane count and the default word-address width of the 2Kx8 lanes.
package bootram_pkg;

  localparam int LANES      = 4;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DONE = 2'd2
  } state_t;

  // An all-zero strobe marks a read on the native bus.
  function automatic logic is_write(input logic [LANES-1:0] strb);
    return |strb;
  endfunction

endpackage

// File: rtl/bootram_ctrl.sv
// Native-bus to four byte-lane boot RAM bridge; the RAM macros live in the parent.
// Build option: define BOOTRAM_WP_EN to write-protect (writes acked, never issued).
module bootram_ctrl
  import bootram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [31:0]       ram_din,
  output logic [3:0]        ram_ce,
  output logic [3:0]        ram_wre,
  output logic              ram_oce,
  input  logic [31:0]       ram_dout
);

  state_t state_q, state_d;
  logic   rd_cap;

  // Upper/lower address bits alias by design; decode happens upstream.
`ifdef BOOTRAM_WP_EN
  logic addr_unused;
  assign addr_unused = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0], mem_wstrb};
`else
  logic addr_unused;
  assign addr_unused = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`endif

  assign ram_oce = 1'b1;

  // RAM strobes are combinational from IDLE so the macro samples them on the
  // same edge the FSM leaves IDLE; this is what makes read latency 3 cycles.
  always_comb begin
    state_d = state_q;
    ram_ad  = '0;
    ram_din = '0;
    ram_ce  = '0;
    ram_wre = '0;
    rd_cap  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          ram_ad = mem_addr[ADDR_W+1:2];
          if (!is_write(mem_wstrb)) begin
            ram_ce  = {LANES{1'b1}};
            state_d = RD;
          end else begin
            ram_din = mem_wdata;
`ifdef BOOTRAM_WP_EN
            ram_ce  = '0;
            ram_wre = '0;
`else
            ram_ce  = mem_wstrb;
            ram_wre = mem_wstrb;
`endif
            state_d = DONE;
          end
        end
      end
      RD: begin
        rd_cap  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset masks every RAM strobe immediately so no write escapes mid-reset.
    if (reset) begin
      state_d = IDLE;
      ram_ad  = '0;
      ram_din = '0;
      ram_ce  = '0;
      ram_wre = '0;
      rd_cap  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (rd_cap) mem_rdata <= ram_dout;
    end
  end

  assign mem_ready = (state_q == DONE) && !reset;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Directed bench for bootram_ctrl with a behavioural 4x2Kx8 synchronous RAM.
module tb_bootram_ctrl;

`ifdef BOOTRAM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ram_din, ram_dout;
  logic [3:0]  mem_wstrb, ram_ce, ram_wre;
  logic [10:0] ram_ad;
  logic        ram_oce;

  int checks = 0;
  int errors = 0;

  bootram_ctrl #(.ADDR_W(11)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_ce(ram_ce), .ram_wre(ram_wre),
    .ram_oce(ram_oce), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: lane n clocked on ce[n]; dout valid after the read edge.
  logic [7:0]  lane_mem [4][2048];
  logic        pl_en;
  logic [10:0] pl_ad;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (pl_en)
        lane_mem[n][pl_ad] <= pl_data[8*n +: 8];
      else if (ram_ce[n]) begin
        if (ram_wre[n]) lane_mem[n][ram_ad] <= ram_din[8*n +: 8];
        else            ram_dout[8*n +: 8]  <= lane_mem[n][ram_ad];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  ce;
    logic [3:0]  wre;
    logic [10:0] ad;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[8];

  // Starts just after a rising edge, returns just after the edge ending DONE,
  // so consecutive calls keep mem_valid high continuously.
  task automatic do_txn(input string tag, input vec_t v);
    int lat;
    bit done, wre_bad;
    mem_valid = 1'b1;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.strb;
    @(negedge clk);
    chk({tag, "_ad"}, {21'd0, ram_ad}, {21'd0, v.ad});
    chk({tag, "_ce"}, {28'd0, ram_ce}, {28'd0, v.ce});
    chk({tag, "_wre"}, {28'd0, ram_wre}, {28'd0, v.wre});
    chk({tag, "_rdy_idle"}, {31'd0, mem_ready}, 32'd0);
    if (v.strb != 4'h0) chk({tag, "_din"}, ram_din, v.wdata);
    lat = 1; done = 0; wre_bad = 0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (ram_wre != 4'h0) wre_bad = 1;
      if (mem_ready) done = 1;
    end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_rdata"}, mem_rdata, v.rdata);
    chk({tag, "_wre_quiet"}, {31'd0, wre_bad}, 32'd0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    pl_en = 1'b0; pl_ad = '0; pl_data = '0;

    vecs[0] = '{32'h0000_0010, 32'h0, 4'h0, 4'hF, 4'h0, 11'd4, 3, 32'h9305_0013};
    vecs[1] = '{32'h0000_0008, 32'h00AB_0000, 4'h4, WP ? 4'h0 : 4'h4, WP ? 4'h0 : 4'h4,
                11'd2, 2, 32'h9305_0013};
    vecs[2] = '{32'h0000_0008, 32'h0, 4'h0, 4'hF, 4'h0, 11'd2, 3,
                WP ? 32'h1122_3344 : 32'h11AB_3344};
    vecs[3] = '{32'h0000_2010, 32'h0, 4'h0, 4'hF, 4'h0, 11'd4, 3, 32'h9305_0013};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hF, WP ? 4'h0 : 4'hF, WP ? 4'h0 : 4'hF,
                11'd0, 2, 32'h9305_0013};
    vecs[5] = '{32'h0000_0000, 32'h0, 4'h0, 4'hF, 4'h0, 11'd0, 3,
                WP ? 32'hA5A5_A5A5 : 32'hFFFF_FFFF};
    vecs[6] = '{32'h0000_2014, 32'h1234_5678, 4'h3, WP ? 4'h0 : 4'h3, WP ? 4'h0 : 4'h3,
                11'd5, 2, WP ? 32'hA5A5_A5A5 : 32'hFFFF_FFFF};
    vecs[7] = '{32'h0000_0014, 32'h0, 4'h0, 4'hF, 4'h0, 11'd5, 3,
                WP ? 32'hCAFE_F00D : 32'hCAFE_5678};

    // Preload the RAM model while the DUT is held in reset.
    @(posedge clk); #1;
    pl_en = 1'b1; pl_ad = 11'd4; pl_data = 32'h9305_0013;
    @(posedge clk); #1;
    pl_ad = 11'd2; pl_data = 32'h1122_3344;
    @(posedge clk); #1;
    pl_ad = 11'd0; pl_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    pl_ad = 11'd5; pl_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_ce", {28'd0, ram_ce}, 32'd0);
    chk("rst_wre", {28'd0, ram_wre}, 32'd0);
    chk("rst_ad", {21'd0, ram_ad}, 32'd0);
    chk("rst_din", ram_din, 32'd0);
    chk("oce", {31'd0, ram_oce}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table: all vectors back-to-back with mem_valid held high.
    for (int i = 0; i < 8; i++) do_txn($sformatf("v%0d", i), vecs[i]);

    // Idle bus: no strobes, no ready, rdata held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_ce", i), {28'd0, ram_ce}, 32'd0);
      chk($sformatf("idle%0d_rdy", i), {31'd0, mem_ready}, 32'd0);
      chk($sformatf("idle%0d_rdata", i), mem_rdata, vecs[7].rdata);
    end
    @(posedge clk); #1;

    // Reset held two cycles mid-read, with the request still valid.
    mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0;
    @(negedge clk);
    chk("mr_ce_idle", {28'd0, ram_ce}, 32'hF);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_ce_rd", {28'd0, ram_ce}, 32'd0);
    chk("mr_rdy_rd", {31'd0, mem_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_ce_2", {28'd0, ram_ce}, 32'd0);
    chk("mr_rdy_2", {31'd0, mem_ready}, 32'd0);
    chk("mr_rdata_2", mem_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("mr_rdy_after", {31'd0, mem_ready}, 32'd0);
    chk("mr_rdata_after", mem_rdata, 32'd0);
    @(posedge clk); #1;

    // Reset in DONE suppresses the acknowledge.
    mem_valid = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF;
    @(negedge clk);
    chk("ad_wre_idle", {28'd0, ram_wre}, WP ? 32'd0 : 32'hF);
    @(posedge clk); #1;
    reset = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    chk("ad_rdy_done", {31'd0, mem_ready}, 32'd0);
    chk("ad_wre_done", {28'd0, ram_wre}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // FSM must be back in IDLE: a fresh read has full 3-cycle latency.
    v = vecs[0];
    do_txn("post_rst", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
